ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the CPU/IO side to the keyboard over the same open-drain PS2KeyboardClk/PS2KeyboardData lines the keyboard receiver listens on. It performs the request-to-send sequence, shifts out data, odd parity and stop on device-generated clock edges, and checks the device ACK. Outputs are drive-low enables; the top level wraps them into tri-state pads, and `busy` lets the receiver discard line activity during a transmission.

## Interface
Parameters:
- INHIBIT_CYCLES, 12000: cycles the host holds clock low (120 µs at 100 MHz).
- START_TIMEOUT, 1500000: cycles allowed from clock release to the first device falling edge (15 ms).
- PACKET_TIMEOUT, 200000: cycles allowed from the first falling edge to the ACK edge (2 ms).
- FILTER_LEN, 8: consecutive identical synchronized samples required to change a filtered line value.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_start  in  1  single-cycle request; sampled only in IDLE.
- tx_data  in  8  command byte; latched on an accepted tx_start.
- ps2_clk_in  in  1  raw PS/2 clock pad value (asynchronous).
- ps2_data_in  in  1  raw PS/2 data pad value (asynchronous).
- ps2_clk_oe  out  1  1 = pull clock low.
- ps2_data_oe  out  1  1 = pull data low.
- busy  out  1  high whenever the state is not IDLE.
- tx_done  out  1  one-cycle pulse: frame acknowledged and lines idle.
- tx_err  out  1  one-cycle pulse: no ACK, or a timeout.

## Operation
- Input conditioning: each line passes through a 2-FF synchronizer and then the filter. The filtered value resets to 1. `fall` is a one-cycle pulse on a filtered clock 1→0 transition.
- Frame register: 10 bits {stop=1, parity=~^tx_data, tx_data}, shifted LSB first. The bit counter runs 0..10.
- States:
  - IDLE: both oe=0. On tx_start, latch the frame, clear the counter, go to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: clk_oe=1, data_oe=1 for exactly one cycle, then go to SEND. Clear the timer.
  - SEND: clk_oe=0, and data_oe holds the start bit (1). On each fall, data_oe = ~frame[0], frame shifts right, bit_cnt increments.
    - After the 10th fall the stop bit is driven (released); go to ACK.
    - If the timer reaches START_TIMEOUT before the 1st fall, go to ERR.
    - If the timer reaches PACKET_TIMEOUT after the 1st fall, go to ERR. The timer is cleared at the 1st fall.
  - ACK: data_oe=0. On the 11th fall, sample filtered data: 0 goes to WAIT_IDLE, 1 goes to ERR. Packet timeout still applies.
  - WAIT_IDLE: wait until filtered clock and data are both 1, then pulse tx_done and go to IDLE. Packet timeout still applies and goes to ERR.
  - ERR: both oe=0, pulse tx_err for one cycle, go to IDLE.
- tx_start while busy is ignored; no queueing.
- rst in any state: on the next edge the state is IDLE and all outputs are 0. The line is released immediately.
- A simultaneous rst and tx_start: reset wins and the request is dropped.

## Timing
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, busy=0, tx_done=0, tx_err=0. Filtered lines reset to 1.
- busy rises the cycle after an accepted tx_start.
- Clock is held low for INHIBIT_CYCLES+1 cycles: INHIBIT plus REQ.
- Edge-detect latency from the pad is 2+FILTER_LEN cycles. A data change follows fall by 1 cycle, well inside the device's ~30–50 µs low phase.
- tx_done and tx_err are mutually exclusive. Each is high for exactly 1 cycle, and busy falls in the same cycle.
- The timer is 21 bits, saturating; the comparison is ≥.

## Structure
- Shared package/header ps2_pkg:
  - state encoding;
  - frame length 11;
  - command constants PS2_CMD_SET_LED=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF, PS2_ACK=8'hFA.
- The keyboard receiver reuses these constants.
- One sub-module, ps2_line_filter (synchronizer plus FILTER_LEN filter plus fall pulse). It is instantiated twice, once for clock and once for data. Fall output is used on clock only.

## Test plan
Bench parameters: INHIBIT_CYCLES=20, START_TIMEOUT=400, PACKET_TIMEOUT=2000, FILTER_LEN=2. The device model uses a 40-cycle clock period.

- tx_data=8'hED with device ACK:
  - clock held low for 21 cycles;
  - data low when the clock is released;
  - device samples on its rising edges, in order, the 8 data bits 1,0,1,1,0,1,1,1 (LSB first), then parity 1, then stop 1;
  - ACK low on edge 11;
  - result: tx_done=1 for one cycle, tx_err never.
- tx_data=8'hF4, device omits the ACK (data high on edge 11) -> tx_err pulse, busy=0, both oe=0.
- Device never clocks -> tx_err exactly START_TIMEOUT cycles after REQ ends; lines released.
- Device stops after 5 falls -> tx_err when PACKET_TIMEOUT expires after the first fall.
- rst asserted during SEND at bit 4 -> next cycle both oe=0 and busy=0; a following tx_start=8'hFF completes normally.
- tx_start pulsed while busy, and a 1-cycle glitch on ps2_clk_in -> second request ignored, and only the original frame is sent. The glitch produces no fall.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, frame geometry and
// the command bytes used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_ERR
    } ps2_tx_state_t;

    // Start + 8 data + parity + stop on the wire.
    localparam int PS2_FRAME_LEN = 11;
    localparam int PS2_TIMER_W   = 21;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    // Bits shifted out after the start bit, LSB first: data, odd parity, stop.
    function automatic logic [PS2_FRAME_LEN-2:0] ps2_tx_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one asynchronous PS/2 pad: 2-FF synchronizer, a FILTER_LEN-sample
// agreement filter, and a one-cycle pulse on a filtered 1->0 transition.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filtered,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1  <= 1'b1;
            sync_q2  <= 1'b1;
            filtered <= 1'b1;
            fall     <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            fall    <= 1'b0;
            // Any sample that agrees with the current value restarts the run,
            // so a short glitch never accumulates towards a change.
            if (sync_q2 == filtered) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filtered <= sync_q2;
                fall     <= ~sync_q2;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, shift out data/parity/stop
// on device clock falls, check the device ACK, report done or error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int PACKET_TIMEOUT = 200000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    // Request handshake: tx_start is a one-cycle strobe that is accepted only
    // while busy is low; busy rises the next cycle and stays high until the
    // cycle in which exactly one of tx_done/tx_err pulses. Requests seen while
    // busy are dropped, never queued.

    localparam int                     FRAME_BITS   = PS2_FRAME_LEN - 1;
    localparam logic [3:0]             LAST_BIT     = 4'(FRAME_BITS - 1);
    localparam logic [PS2_TIMER_W-1:0] INHIBIT_LAST = PS2_TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [PS2_TIMER_W-1:0] START_LIM    = PS2_TIMER_W'(START_TIMEOUT);
    localparam logic [PS2_TIMER_W-1:0] PKT_LIM      = PS2_TIMER_W'(PACKET_TIMEOUT);

    ps2_tx_state_t           state;
    logic [FRAME_BITS-1:0]   frame;
    logic [3:0]              bit_cnt;
    logic [PS2_TIMER_W-1:0]  timer;
    logic [PS2_TIMER_W-1:0]  timer_inc;
    logic [PS2_TIMER_W-1:0]  send_limit;
    logic                    clk_filt;
    logic                    clk_fall;
    logic                    data_filt;
    logic                    data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk      (clk),
        .rst      (rst),
        .raw      (ps2_clk_in),
        .filtered (clk_filt),
        .fall     (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk      (clk),
        .rst      (rst),
        .raw      (ps2_data_in),
        .filtered (data_filt),
        .fall     (data_fall_unused)
    );

    assign timer_inc  = (&timer) ? timer : timer + 1'b1;
    // Until the device produces its first fall it gets the long start window.
    assign send_limit = (bit_cnt == 4'd0) ? START_LIM : PKT_LIM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            frame       <= '0;
            bit_cnt     <= '0;
            timer       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_start) begin
                        frame      <= ps2_tx_frame(tx_data);
                        bit_cnt    <= '0;
                        timer      <= '0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (timer >= INHIBIT_LAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= ST_REQ;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_REQ: begin
                    // Releasing clock with data held low is the start bit.
                    ps2_clk_oe <= 1'b0;
                    timer      <= '0;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (clk_fall) begin
                        ps2_data_oe <= ~frame[0];
                        frame       <= {1'b0, frame[FRAME_BITS-1:1]};
                        bit_cnt     <= bit_cnt + 1'b1;
                        timer       <= (bit_cnt == 4'd0) ? '0 : timer_inc;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_ACK;
                        end
                    end else if (timer >= send_limit) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= ST_ERR;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_ACK: begin
                    ps2_data_oe <= 1'b0;
                    if (clk_fall) begin
                        state <= data_filt ? ST_ERR : ST_WAIT_IDLE;
                    end else if (timer >= PKT_LIM) begin
                        state <= ST_ERR;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (clk_filt && data_filt) begin
                        tx_done <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (timer >= PKT_LIM) begin
                        state <= ST_ERR;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_ERR: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_err      <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device drives the clock and checks
// what it samples against frames built from the byte with plain arithmetic.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH   = 20;
    localparam int ST_TO = 400;
    localparam int PK_TO = 2000;
    localparam int FLEN  = 2;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       glitch = 1'b0;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    // Open-drain wiring: anyone pulling low wins.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe & ~glitch;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (ST_TO),
        .PACKET_TIMEOUT (PK_TO),
        .FILTER_LEN     (FLEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- result monitor ----------------
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0, done_hi = 0, err_cnt = 0, err_hi = 0;
    int   err_cyc = 0;
    logic done_prev = 1'b0, err_prev = 1'b0;
    logic done_busy, err_busy, err_clk_oe, err_data_oe;

    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_hi = done_hi + 1;
            if (!done_prev) begin
                done_cnt  = done_cnt + 1;
                done_busy = busy;
            end
        end
        if (tx_err === 1'b1) begin
            err_hi = err_hi + 1;
            if (!err_prev) begin
                err_cnt     = err_cnt + 1;
                err_cyc     = cyc;
                err_busy    = busy;
                err_clk_oe  = ps2_clk_oe;
                err_data_oe = ps2_data_oe;
            end
        end
        done_prev = (tx_done === 1'b1);
        err_prev  = (tx_err === 1'b1);
    end

    // ---------------- reference model / scoreboard ----------------
    logic [0:0] exp_q[$];

    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic push_expected(input logic [7:0] d);
        logic [9:0] f;
        f = ref_frame(d);
        for (int i = 0; i < 10; i++) exp_q.push_back(f[i]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_tx(input logic [7:0] d, output logic busy_seen);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start  = 1'b0;
        busy_seen = busy;
    endtask

    task automatic measure_inhibit(output int n, output logic data_line);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (ps2_clk_oe !== 1'b1) break;
            n++;
            @(negedge clk);
        end
        data_line = ps2_data_in;
    endtask

    task automatic dev_clock(input int n_falls, input bit give_ack, input int glitch_at,
                             output logic [9:0] got, output int t_first);
        got     = '1;
        t_first = 0;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= n_falls; k++) begin
            dev_clk = 1'b0;
            if (k == 1) t_first = cyc;
            repeat (HALF) @(negedge clk);
            if (k <= 10) got[k-1] = ps2_data_in;
            dev_clk = 1'b1;
            if (k == 10 && give_ack) dev_data = 1'b0;
            if (k < n_falls) begin
                if (k == glitch_at) begin
                    repeat (5) @(negedge clk);
                    glitch = 1'b1;
                    @(negedge clk);
                    glitch = 1'b0;
                    repeat (HALF - 6) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
            end
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_result(input int budget, input int base_done, input int base_err,
                               output int kind);
        kind = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != base_done) begin kind = 1; break; end
            if (err_cnt != base_err) begin kind = 2; break; end
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst      = 1'b1;
        tx_start = 1'b1;
        tx_data  = PS2_CMD_RESET;
        repeat (3) @(negedge clk);
        total++; if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); end
        total++; if (ps2_data_oe !== 1'b0) begin bad++; $display("FAIL reset_data_oe got=%b exp=0", ps2_data_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_tx_done got=%b exp=0", tx_done); end
        total++; if (tx_err !== 1'b0) begin bad++; $display("FAIL reset_tx_err got=%b exp=0", tx_err); end
        rst      = 1'b0;
        tx_start = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
            bad++; $display("FAIL reset_drops_start busy=%b clk_oe=%b exp=0,0", busy, ps2_clk_oe);
        end
    endtask

    task automatic test_ack_ed();
        int bd = done_cnt, be = err_cnt, hd = done_hi;
        int n, kind, tf;
        logic bs, dl;
        logic [9:0] got;
        push_expected(PS2_CMD_SET_LED);
        start_tx(PS2_CMD_SET_LED, bs);
        total++; if (bs !== 1'b1) begin bad++; $display("FAIL ed_busy_rise got=%b exp=1", bs); end
        measure_inhibit(n, dl);
        total++; if (n != INH + 1) begin bad++; $display("FAIL ed_clk_low_cycles got=%0d exp=%0d", n, INH + 1); end
        total++; if (dl !== 1'b0) begin bad++; $display("FAIL ed_start_bit got=%b exp=0", dl); end
        dev_clock(11, 1'b1, 0, got, tf);
        wait_result(300, bd, be, kind);
        total++; if (kind != 1) begin bad++; $display("FAIL ed_result got=%0d exp=1(done)", kind); end
        for (int i = 0; i < 10; i++) begin
            logic [0:0] e;
            e = exp_q.pop_front();
            total++; if (got[i] !== e[0]) begin bad++; $display("FAIL ed_bit%0d got=%b exp=%b", i, got[i], e[0]); end
        end
        total++; if (done_hi - hd != 1) begin bad++; $display("FAIL ed_done_width got=%0d exp=1", done_hi - hd); end
        total++; if (done_busy !== 1'b0) begin bad++; $display("FAIL ed_busy_at_done got=%b exp=0", done_busy); end
        total++; if (err_cnt != be) begin bad++; $display("FAIL ed_no_err got=%0d exp=0", err_cnt - be); end
    endtask

    task automatic test_random_frames();
        for (int r = 0; r < 4; r++) begin
            int bd = done_cnt, be = err_cnt;
            int n, kind, tf;
            logic bs, dl;
            logic [9:0] got;
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            push_expected(d);
            start_tx(d, bs);
            measure_inhibit(n, dl);
            total++; if (n != INH + 1 || dl !== 1'b0) begin
                bad++; $display("FAIL rnd_request d=%02h low=%0d start=%b exp=%0d,0", d, n, dl, INH + 1);
            end
            dev_clock(11, 1'b1, 0, got, tf);
            wait_result(300, bd, be, kind);
            total++; if (kind != 1) begin bad++; $display("FAIL rnd_result d=%02h got=%0d exp=1", d, kind); end
            for (int i = 0; i < 10; i++) begin
                logic [0:0] e;
                e = exp_q.pop_front();
                total++; if (got[i] !== e[0]) begin bad++; $display("FAIL rnd_bit%0d d=%02h got=%b exp=%b", i, d, got[i], e[0]); end
            end
        end
    endtask

    task automatic test_no_ack();
        int bd = done_cnt, be = err_cnt, he = err_hi;
        int n, kind, tf;
        logic bs, dl;
        logic [9:0] got;
        start_tx(PS2_CMD_ENABLE, bs);
        measure_inhibit(n, dl);
        dev_clock(11, 1'b0, 0, got, tf);
        wait_result(300, bd, be, kind);
        total++; if (kind != 2) begin bad++; $display("FAIL noack_result got=%0d exp=2(err)", kind); end
        total++; if (err_hi - he != 1) begin bad++; $display("FAIL noack_err_width got=%0d exp=1", err_hi - he); end
        total++; if (err_busy !== 1'b0 || err_clk_oe !== 1'b0 || err_data_oe !== 1'b0) begin
            bad++; $display("FAIL noack_release busy=%b clk_oe=%b data_oe=%b exp=0,0,0", err_busy, err_clk_oe, err_data_oe);
        end
        total++; if (done_cnt != bd) begin bad++; $display("FAIL noack_no_done got=%0d exp=0", done_cnt - bd); end
    endtask

    task automatic test_start_timeout();
        int bd = done_cnt, be = err_cnt;
        int n, kind, t0, dt;
        logic bs, dl;
        start_tx(8'($urandom_range(0, 255)), bs);
        measure_inhibit(n, dl);
        t0 = cyc;
        wait_result(1000, bd, be, kind);
        dt = err_cyc - t0;
        total++; if (kind != 2) begin bad++; $display("FAIL start_to_result got=%0d exp=2(err)", kind); end
        total++; if (dt < ST_TO || dt > ST_TO + 4) begin
            bad++; $display("FAIL start_to_time got=%0d exp=%0d..%0d", dt, ST_TO, ST_TO + 4);
        end
        total++; if (err_busy !== 1'b0 || err_clk_oe !== 1'b0 || err_data_oe !== 1'b0) begin
            bad++; $display("FAIL start_to_release busy=%b clk_oe=%b data_oe=%b exp=0,0,0", err_busy, err_clk_oe, err_data_oe);
        end
    endtask

    task automatic test_packet_timeout();
        int bd = done_cnt, be = err_cnt;
        int n, kind, tf, dt;
        logic bs, dl;
        logic [9:0] got, f;
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        f = ref_frame(d);
        start_tx(d, bs);
        measure_inhibit(n, dl);
        dev_clock(5, 1'b0, 0, got, tf);
        wait_result(3000, bd, be, kind);
        dt = err_cyc - tf;
        total++; if (got[4:0] !== f[4:0]) begin bad++; $display("FAIL pkt_to_bits got=%05b exp=%05b", got[4:0], f[4:0]); end
        total++; if (kind != 2) begin bad++; $display("FAIL pkt_to_result got=%0d exp=2(err)", kind); end
        total++; if (dt < PK_TO || dt > PK_TO + 10) begin
            bad++; $display("FAIL pkt_to_time got=%0d exp=%0d..%0d", dt, PK_TO, PK_TO + 10);
        end
        total++; if (err_clk_oe !== 1'b0 || err_data_oe !== 1'b0) begin
            bad++; $display("FAIL pkt_to_release clk_oe=%b data_oe=%b exp=0,0", err_clk_oe, err_data_oe);
        end
    endtask

    task automatic test_reset_mid_send();
        int bd = done_cnt, be = err_cnt;
        int n, kind, tf;
        logic bs, dl;
        logic [9:0] got;
        start_tx(8'($urandom_range(0, 255)), bs);
        measure_inhibit(n, dl);
        dev_clock(4, 1'b0, 0, got, tf);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_release clk_oe=%b data_oe=%b busy=%b exp=0,0,0", ps2_clk_oe, ps2_data_oe, busy);
        end
        total++; if (done_cnt != bd || err_cnt != be) begin
            bad++; $display("FAIL midrst_no_pulse done=%0d err=%0d exp=0,0", done_cnt - bd, err_cnt - be);
        end
        repeat (5) @(negedge clk);
        bd = done_cnt;
        be = err_cnt;
        push_expected(PS2_CMD_RESET);
        start_tx(PS2_CMD_RESET, bs);
        measure_inhibit(n, dl);
        total++; if (n != INH + 1) begin bad++; $display("FAIL midrst_ff_low got=%0d exp=%0d", n, INH + 1); end
        dev_clock(11, 1'b1, 0, got, tf);
        wait_result(300, bd, be, kind);
        total++; if (kind != 1) begin bad++; $display("FAIL midrst_ff_result got=%0d exp=1(done)", kind); end
        for (int i = 0; i < 10; i++) begin
            logic [0:0] e;
            e = exp_q.pop_front();
            total++; if (got[i] !== e[0]) begin bad++; $display("FAIL midrst_ff_bit%0d got=%b exp=%b", i, got[i], e[0]); end
        end
    endtask

    task automatic test_busy_ignore_glitch();
        int bd = done_cnt, be = err_cnt;
        int n, kind, tf;
        logic bs, dl;
        logic [9:0] got;
        logic [7:0] a;
        a = 8'($urandom_range(0, 255));
        push_expected(a);
        start_tx(a, bs);
        @(negedge clk);
        tx_data  = ~a;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        measure_inhibit(n, dl);
        total++; if (n != INH + 1 - 2) begin bad++; $display("FAIL busy_ign_low got=%0d exp=%0d", n, INH - 1); end
        dev_clock(11, 1'b1, 3, got, tf);
        wait_result(300, bd, be, kind);
        total++; if (kind != 1) begin bad++; $display("FAIL busy_ign_result got=%0d exp=1(done)", kind); end
        for (int i = 0; i < 10; i++) begin
            logic [0:0] e;
            e = exp_q.pop_front();
            total++; if (got[i] !== e[0]) begin bad++; $display("FAIL busy_ign_bit%0d got=%b exp=%b", i, got[i], e[0]); end
        end
        repeat (100) @(negedge clk);
        total++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
            bad++; $display("FAIL busy_ign_not_queued busy=%b clk_oe=%b exp=0,0", busy, ps2_clk_oe);
        end
        total++; if (done_cnt - bd != 1 || err_cnt != be) begin
            bad++; $display("FAIL busy_ign_pulses done=%0d err=%0d exp=1,0", done_cnt - bd, err_cnt - be);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_ack_ed();
        test_random_frames();
        test_no_ack();
        test_start_timeout();
        test_packet_timeout();
        test_reset_mid_send();
        test_busy_ignore_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
